burst_memory_model: RTL
=======================

Name: burst_memory_model

Overview:
Parametrised word-addressed external memory model for the MESI coherency testbench. It is the successor to the single-beat memory and adds true multi-beat bursts with per-beat write data, read backpressure, configurable access latency, size checking and error responses. It sits behind the cache/bus controller on the m_* channel and backs all line fills and writebacks.

Parameters:
DATA_W, 32, data beat width in bits; must be a multiple of 8.
ADDR_W, 18, word-address width; memory depth is 2**ADDR_W words.
MAX_BURST, 16, maximum beats per transaction.
RD_LAT, 2, cycles from read acceptance to first m_rvalid; minimum 1.
WR_LAT, 1, cycles from last write beat to m_w_resp; minimum 1.
CLEAR_ON_RESET, 1, 1 = all words zeroed while rstn is low.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
m_addr  in  32  word address of the first beat; bits [ADDR_W-1:0] are used
m_awvalid  in  1  write request, sampled in IDLE only
m_arvalid  in  1  read request, sampled in IDLE only
m_wsize  in  12  write length in bytes
m_rsize  in  12  read length in bytes
m_req_ready  out  1  high in IDLE; a request is accepted when valid and ready are both high
m_wvalid  in  1  write data beat valid
m_wdata  in  DATA_W  write data beat
m_wready  out  1  high in WR_DATA
m_rdata  out  DATA_W  read data beat
m_rvalid  out  1  read beat valid
m_rlast  out  1  final read beat
m_rready  in  1  read beat consumed
m_w_resp  out  2  write response: 01 OKAY, 10 SLVERR; one-cycle pulse
m_r_resp  out  2  read response, same encoding; asserted with the final beat

Behaviour:
- Beat count: BEATS = size / (DATA_W/8).
- A size is legal when it is nonzero, a multiple of DATA_W/8, and BEATS <= MAX_BURST.
- Reset, sampled at the clk edge with rstn low:
  - The FSM goes to IDLE and all counters clear.
  - m_rdata=0, m_rvalid=0, m_rlast=0, m_wready=0, m_w_resp=00, m_r_resp=00, m_req_ready=0 during reset.
  - An in-flight burst is abandoned and no response is issued.
  - Memory is zeroed only if CLEAR_ON_RESET=1.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA.
- IDLE:
  - If m_awvalid and m_arvalid are both high, the write is accepted and the read stays pending; the master must hold it.
  - On acceptance, m_addr (modulo depth) and BEATS are latched.
  - A legal write goes to WR_DATA; a legal read goes to RD_WAIT.
  - An illegal size goes straight to WR_RESP with SLVERR (write) or issues one beat of m_rdata=0 with m_rvalid=1, m_rlast=1, m_r_resp=10 (read), then returns to IDLE. Memory is untouched.
- WR_DATA:
  - Each cycle with m_wvalid=1, m_wdata is written to mem[base+beat], wrapping modulo 2**ADDR_W, and beat increments.
  - Cycles with m_wvalid=0 are stalls.
  - After beat BEATS-1 is written, go to WR_RESP.
- WR_RESP:
  - Wait WR_LAT cycles, then drive m_w_resp for exactly one cycle and return to IDLE.
  - The write data is visible to a read accepted in the following cycle.
- RD_WAIT:
  - Count RD_LAT-1 cycles, then go to RD_DATA.
  - The first m_rvalid appears RD_LAT cycles after the acceptance edge.
- RD_DATA:
  - Drive m_rdata=mem[base+beat] with m_rvalid=1.
  - m_rdata, m_rvalid and m_rlast stay stable while m_rready=0.
  - A beat advances only on m_rvalid & m_rready, giving back-to-back beats when m_rready is held high.
  - m_rlast and m_r_resp=01 accompany the final beat.
  - After that beat is consumed, go to IDLE with m_rvalid=0 and m_rresp=00 on the next cycle.
- Read address wrap: same as writes.
- Outputs are registered and there is no combinational input-to-output path.
- m_wvalid outside WR_DATA is ignored.

Test Plan:
- Reset: hold rstn low 3 cycles, then issue a 16-byte read at 0x100 -> 4 beats of 0, first m_rvalid 2 cycles after acceptance, m_rlast on beat 4, m_r_resp=01.
- Burst write/read: write 32 bytes at 0x40 with data 0xA0..0xA7 -> one m_w_resp=01 pulse. Read back 32 bytes -> 0xA0..0xA7 in order, back-to-back.
- Backpressure: 4-beat read with m_rready toggling 1,0,0,1,... -> each beat held stable until consumed, no beat lost or duplicated, m_rlast only on the 4th.
- Illegal sizes: m_wsize=6 -> SLVERR and memory unchanged. m_rsize=0 -> single beat with m_rlast=1 and m_r_resp=10. Size 68 (17 beats) -> SLVERR.
- Wrap and collision: 4-beat write at 0x3FFFE (ADDR_W=18) -> words 0x3FFFE, 0x3FFFF, 0x0, 0x1 written. Simultaneous awvalid and arvalid -> write serviced first and the read accepted after m_w_resp.
- Mid-burst reset: assert rstn low during beat 2 of a 4-beat write -> no m_w_resp, FSM in IDLE, m_req_ready=1 after reset releases.

Source files
------------

// File: rtl/burst_memory_model.sv
// Word-addressed burst memory model: multi-beat writes and reads with
// programmable access latency, size checking, read backpressure and error
// responses.
module burst_memory_model #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned RD_LAT         = 2,
    parameter int unsigned WR_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       m_addr,
    input  logic              m_awvalid,
    input  logic              m_arvalid,
    input  logic [11:0]       m_wsize,
    input  logic [11:0]       m_rsize,
    output logic              m_req_ready,
    input  logic              m_wvalid,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_wready,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_rvalid,
    output logic              m_rlast,
    input  logic              m_rready,
    output logic [1:0]        m_w_resp,
    output logic [1:0]        m_r_resp
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned CNT_W   = $clog2(MAX_BURST + 1);
    localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] RESP_NONE   = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_WAIT,
        RD_DATA
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] rdata_d;
    logic              rvalid_d;
    logic              rlast_d;
    logic [1:0]        rresp_d;
    logic [1:0]        wresp_d;

    logic              mem_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] nxt_addr;

    logic [11:0]       wbeats, rbeats;
    logic              wsize_ok, rsize_ok;
    logic              unused_addr;

    // Only the low ADDR_W address bits select a word.
    assign unused_addr = ^m_addr[31:ADDR_W];

    // Size decode: legal when nonzero, whole beats, and within the burst limit.
    assign wbeats   = m_wsize / 12'(BYTES);
    assign rbeats   = m_rsize / 12'(BYTES);
    assign wsize_ok = (m_wsize != 12'd0) && ((m_wsize % 12'(BYTES)) == 12'd0)
                      && (wbeats <= 12'(MAX_BURST));
    assign rsize_ok = (m_rsize != 12'd0) && ((m_rsize % 12'(BYTES)) == 12'd0)
                      && (rbeats <= 12'(MAX_BURST));

    // Beat addresses wrap modulo the memory depth.
    assign cur_addr = base_q + ADDR_W'(beat_q);
    assign nxt_addr = base_q + ADDR_W'(beat_q + CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        next_state = state;
        base_d     = base_q;
        beats_d    = beats_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        err_d      = err_q;
        rdata_d    = m_rdata;
        rvalid_d   = m_rvalid;
        rlast_d    = m_rlast;
        rresp_d    = m_r_resp;
        wresp_d    = RESP_NONE;
        mem_we     = 1'b0;

        case (state)
            IDLE: begin
                if (m_req_ready && m_awvalid) begin
                    base_d = m_addr[ADDR_W-1:0];
                    beat_d = '0;
                    lat_d  = '0;
                    if (wsize_ok) begin
                        beats_d    = CNT_W'(wbeats);
                        err_d      = 1'b0;
                        next_state = WR_DATA;
                    end else begin
                        err_d      = 1'b1;
                        next_state = WR_RESP;
                    end
                end else if (m_req_ready && m_arvalid) begin
                    base_d = m_addr[ADDR_W-1:0];
                    beat_d = '0;
                    lat_d  = '0;
                    if (rsize_ok) begin
                        beats_d    = CNT_W'(rbeats);
                        err_d      = 1'b0;
                        next_state = RD_WAIT;
                    end else begin
                        // Single zero beat carrying the error response.
                        beats_d    = CNT_W'(1);
                        err_d      = 1'b1;
                        rdata_d    = '0;
                        rvalid_d   = 1'b1;
                        rlast_d    = 1'b1;
                        rresp_d    = RESP_SLVERR;
                        next_state = RD_DATA;
                    end
                end
            end

            WR_DATA: begin
                if (m_wvalid) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == beats_q - CNT_W'(1)) begin
                        lat_d      = '0;
                        next_state = WR_RESP;
                    end
                end
            end

            WR_RESP: begin
                if (lat_q == LAT_W'(WR_LAT - 1)) begin
                    wresp_d    = err_q ? RESP_SLVERR : RESP_OKAY;
                    next_state = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            RD_WAIT: begin
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    rdata_d    = mem[cur_addr];
                    rvalid_d   = 1'b1;
                    rlast_d    = (beats_q == CNT_W'(1));
                    rresp_d    = (beats_q == CNT_W'(1)) ? RESP_OKAY : RESP_NONE;
                    next_state = RD_DATA;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            RD_DATA: begin
                if (m_rready) begin
                    if (m_rlast) begin
                        rdata_d    = '0;
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        rresp_d    = RESP_NONE;
                        next_state = IDLE;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                        rdata_d = mem[nxt_addr];
                        rlast_d = ((beat_q + CNT_W'(2)) == beats_q);
                        rresp_d = ((beat_q + CNT_W'(2)) == beats_q) ? RESP_OKAY : RESP_NONE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered counters and outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            base_q      <= '0;
            beats_q     <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            err_q       <= 1'b0;
            m_rdata     <= '0;
            m_rvalid    <= 1'b0;
            m_rlast     <= 1'b0;
            m_r_resp    <= RESP_NONE;
            m_w_resp    <= RESP_NONE;
            m_wready    <= 1'b0;
            m_req_ready <= 1'b0;
        end else begin
            base_q      <= base_d;
            beats_q     <= beats_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            err_q       <= err_d;
            m_rdata     <= rdata_d;
            m_rvalid    <= rvalid_d;
            m_rlast     <= rlast_d;
            m_r_resp    <= rresp_d;
            m_w_resp    <= wresp_d;
            m_wready    <= (next_state == WR_DATA);
            m_req_ready <= (next_state == IDLE);
        end
    end

    // Storage array; optionally zeroed while reset is held.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            if (CLEAR_ON_RESET != 0) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (mem_we) begin
            mem[cur_addr] <= m_wdata;
        end
    end

endmodule
